seg7_arbiter: RTL and testbench

Shares the single 8-digit 7-segment display between two requesters: the CPU MMIO path and the debug/monitor path. It accepts 32-bit display words over a req/ack handshake and arbitrates between the two sources. Each grant is held on the display for a minimum dwell time so a value stays readable. Its `disp_data` output drives the display driver's 32-bit data input directly.

---
 rtl/seg7_arbiter_if.sv | 23 ++
 rtl/seg7_arbiter.sv | 152 +++++++++++++++
 tb/tb_seg7_arbiter.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/seg7_arbiter_if.sv
// Display-sharing bus between the CPU and debug requesters and the seg7_arbiter.
// Requesters hold req/data until they see their one-cycle ack pulse.
interface seg7_arbiter_if;
    logic        req_cpu;
    logic [31:0] data_cpu;
    logic        ack_cpu;
    logic        req_dbg;
    logic [31:0] data_dbg;
    logic        ack_dbg;
    logic [31:0] disp_data;
    logic        disp_src;
    logic        busy;

    modport master (
        output req_cpu, data_cpu, req_dbg, data_dbg,
        input  ack_cpu, ack_dbg, disp_data, disp_src, busy
    );

    modport slave (
        input  req_cpu, data_cpu, req_dbg, data_dbg,
        output ack_cpu, ack_dbg, disp_data, disp_src, busy
    );
endinterface

// File: rtl/seg7_arbiter.sv
// Two-source arbiter for the 8-digit display with a minimum dwell per grant.
// Define SEG_RR_EN for round-robin tie breaking; otherwise the CPU wins every tie.
module seg7_arbiter #(
    parameter int unsigned HOLD_CYCLES = 32'd50_000_000
) (
    input  logic          clk,
    input  logic          rst,
    seg7_arbiter_if.slave bus
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    localparam logic [31:0] RELOAD = HOLD_CYCLES - 32'd1;

    state_t      state_r;
    state_t      state_s;
    logic [31:0] cnt_r;
    logic [31:0] cnt_s;
    logic [31:0] disp_data_r;
    logic [31:0] disp_data_s;
    logic        disp_src_r;
    logic        disp_src_s;
    logic        ack_cpu_r;
    logic        ack_cpu_s;
    logic        ack_dbg_r;
    logic        ack_dbg_s;
    logic        busy_r;
    logic        busy_s;
    logic        last_src_r;
    logic        last_src_s;

    logic        eff_cpu_s;
    logic        eff_dbg_s;
    logic        any_req_s;
    logic        owner_eff_s;
    logic        win_src_s;
    logic        grant_s;
    logic        grant_src_s;

    // A request in its own ack cycle is the word just accepted, so it is masked.
    assign eff_cpu_s   = bus.req_cpu & ~ack_cpu_r;
    assign eff_dbg_s   = bus.req_dbg & ~ack_dbg_r;
    assign any_req_s   = eff_cpu_s | eff_dbg_s;
    assign owner_eff_s = disp_src_r ? eff_dbg_s : eff_cpu_s;

    // Pick the winning source among effective requests (0 = CPU, 1 = debug).
    always_comb begin
        win_src_s = 1'b0;
        if (eff_cpu_s && eff_dbg_s) begin
`ifdef SEG_RR_EN
            win_src_s = ~last_src_r;
`else
            win_src_s = 1'b0;
`endif
        end else if (eff_dbg_s) begin
            win_src_s = 1'b1;
        end else begin
            win_src_s = 1'b0;
        end
    end

    // Next-state and dwell counter logic.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        grant_s     = 1'b0;
        grant_src_s = win_src_s;
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) begin
                    grant_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (cnt_r != 32'd0) begin
                    if (owner_eff_s) begin
                        grant_s     = 1'b1;
                        grant_src_s = disp_src_r;
                    end else begin
                        cnt_s = cnt_r - 32'd1;
                    end
                end else if (any_req_s) begin
                    grant_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = 32'd0;
            end
        endcase
        if (grant_s) begin
            state_s = ST_HOLD;
            cnt_s   = RELOAD;
        end else begin
            cnt_s = cnt_s;
        end
    end

    // Output register next values; display only moves on a grant.
    always_comb begin
        disp_data_s = disp_data_r;
        disp_src_s  = disp_src_r;
        last_src_s  = last_src_r;
        if (grant_s) begin
            disp_data_s = grant_src_s ? bus.data_dbg : bus.data_cpu;
            disp_src_s  = grant_src_s;
            last_src_s  = grant_src_s;
        end else begin
            disp_data_s = disp_data_r;
        end
        ack_cpu_s = grant_s & ~grant_src_s;
        ack_dbg_s = grant_s & grant_src_s;
        busy_s    = (state_s == ST_HOLD);
    end

    // State and output registers; reset aborts any dwell and pending ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 32'd0;
            disp_data_r <= 32'd0;
            disp_src_r  <= 1'b0;
            ack_cpu_r   <= 1'b0;
            ack_dbg_r   <= 1'b0;
            busy_r      <= 1'b0;
            last_src_r  <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            disp_data_r <= disp_data_s;
            disp_src_r  <= disp_src_s;
            ack_cpu_r   <= ack_cpu_s;
            ack_dbg_r   <= ack_dbg_s;
            busy_r      <= busy_s;
            last_src_r  <= last_src_s;
        end
    end

    assign bus.disp_data = disp_data_r;
    assign bus.disp_src  = disp_src_r;
    assign bus.ack_cpu   = ack_cpu_r;
    assign bus.ack_dbg   = ack_dbg_r;
    assign bus.busy      = busy_r;

endmodule

// File: tb/tb_seg7_arbiter.sv
// Directed-vector bench for seg7_arbiter with HOLD_CYCLES=4; tie expectations
// follow SEG_RR_EN when the bench is compiled with it.
module tb_seg7_arbiter;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    seg7_arbiter_if bus ();

    seg7_arbiter #(.HOLD_CYCLES(32'd4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rc;
        logic [31:0] dc;
        logic        rd;
        logic [31:0] dd;
        logic [35:0] exp;
    } vec_t;

    vec_t tbl [19];

    function automatic logic [35:0] ex(input logic [31:0] d, input logic s,
                                       input logic ac, input logic ad, input logic b);
        return {d, s, ac, ad, b};
    endfunction

    function automatic logic [35:0] obs();
        return {bus.disp_data, bus.disp_src, bus.ack_cpu, bus.ack_dbg, bus.busy};
    endfunction

    task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (data,src,ack_cpu,ack_dbg,busy)", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.req_cpu = 1'b0;
        bus.req_dbg = 1'b0;
        #1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    localparam logic [31:0] A = 32'h1234_5678;
    localparam logic [31:0] B = 32'hDEAD_BEEF;
    localparam logic [31:0] C = 32'h0000_CAFE;
    localparam logic [31:0] D = 32'h0F0F_0F0F;
    localparam logic [31:0] E = 32'h0000_0002;
    localparam logic [31:0] Z = 32'h0000_0000;

    initial begin
        logic        w_src;
        logic [31:0] cur_cpu;
        logic [31:0] cur_dbg;
        logic [31:0] w_data;
        logic [31:0] l_data;

        clk = 1'b0;
        rst = 1'b0;
        n_vec = 0;
        n_err = 0;
        bus.req_cpu  = 1'b0;
        bus.data_cpu = 32'd0;
        bus.req_dbg  = 1'b0;
        bus.data_dbg = 32'd0;

        tbl[0]  = '{1'b0, Z, 1'b0, Z, ex(Z, 1'b0, 1'b0, 1'b0, 1'b0)};
        tbl[1]  = '{1'b1, A, 1'b0, Z, ex(A, 1'b0, 1'b1, 1'b0, 1'b1)};
        tbl[2]  = '{1'b0, Z, 1'b0, Z, ex(A, 1'b0, 1'b0, 1'b0, 1'b1)};
        tbl[3]  = '{1'b0, Z, 1'b1, B, ex(A, 1'b0, 1'b0, 1'b0, 1'b1)};
        tbl[4]  = '{1'b0, Z, 1'b1, B, ex(A, 1'b0, 1'b0, 1'b0, 1'b1)};
        tbl[5]  = '{1'b0, Z, 1'b1, B, ex(B, 1'b1, 1'b0, 1'b1, 1'b1)};
        tbl[6]  = '{1'b0, Z, 1'b0, Z, ex(B, 1'b1, 1'b0, 1'b0, 1'b1)};
        tbl[7]  = '{1'b0, Z, 1'b0, Z, ex(B, 1'b1, 1'b0, 1'b0, 1'b1)};
        tbl[8]  = '{1'b0, Z, 1'b0, Z, ex(B, 1'b1, 1'b0, 1'b0, 1'b1)};
        tbl[9]  = '{1'b0, Z, 1'b0, Z, ex(B, 1'b1, 1'b0, 1'b0, 1'b0)};
        tbl[10] = '{1'b0, Z, 1'b0, Z, ex(B, 1'b1, 1'b0, 1'b0, 1'b0)};
        tbl[11] = '{1'b0, Z, 1'b1, C, ex(C, 1'b1, 1'b0, 1'b1, 1'b1)};
        tbl[12] = '{1'b0, Z, 1'b1, C, ex(C, 1'b1, 1'b0, 1'b0, 1'b1)};
        tbl[13] = '{1'b0, Z, 1'b0, Z, ex(C, 1'b1, 1'b0, 1'b0, 1'b1)};
        tbl[14] = '{1'b1, D, 1'b0, Z, ex(C, 1'b1, 1'b0, 1'b0, 1'b1)};
        tbl[15] = '{1'b1, D, 1'b0, Z, ex(D, 1'b0, 1'b1, 1'b0, 1'b1)};
        tbl[16] = '{1'b1, D, 1'b0, Z, ex(D, 1'b0, 1'b0, 1'b0, 1'b1)};
        tbl[17] = '{1'b1, E, 1'b0, Z, ex(E, 1'b0, 1'b1, 1'b0, 1'b1)};
        tbl[18] = '{1'b0, Z, 1'b0, Z, ex(E, 1'b0, 1'b0, 1'b0, 1'b1)};

        // Asynchronous reset with no clock edge in between.
        #2;
        rst = 1'b1;
        #1;
        chk("reset_async", obs(), ex(Z, 1'b0, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 19; i++) begin
            bus.req_cpu  = tbl[i].rc;
            bus.data_cpu = tbl[i].dc;
            bus.req_dbg  = tbl[i].rd;
            bus.data_dbg = tbl[i].dd;
            step();
            chk($sformatf("vec%0d", i), obs(), tbl[i].exp);
        end

        // Reset mid-HOLD while an ack is pending.
        bus.req_cpu  = 1'b1;
        bus.data_cpu = A;
        step();
        chk("pre_rst_refresh", obs(), ex(A, 1'b0, 1'b1, 1'b0, 1'b1));
        bus.req_cpu = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_hold", obs(), ex(Z, 1'b0, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        rst = 1'b0;
        bus.req_dbg  = 1'b1;
        bus.data_dbg = 32'hCAFE_0000;
        step();
        chk("post_rst_grant", obs(), ex(32'hCAFE_0000, 1'b1, 1'b0, 1'b1, 1'b1));
        bus.req_dbg = 1'b0;

        // Simultaneous requests from IDLE; loser waits the full dwell.
        do_reset();
        bus.req_cpu  = 1'b1;
        bus.data_cpu = 32'h1111_1111;
        bus.req_dbg  = 1'b1;
        bus.data_dbg = B;
`ifdef SEG_RR_EN
        w_src = 1'b1;
`else
        w_src = 1'b0;
`endif
        w_data = w_src ? B : 32'h1111_1111;
        l_data = w_src ? 32'h1111_1111 : B;
        step();
        chk("tie_first", obs(), ex(w_data, w_src, ~w_src, w_src, 1'b1));
        if (w_src) bus.req_dbg = 1'b0;
        else       bus.req_cpu = 1'b0;
        for (int k = 0; k < 3; k++) step();
        chk("tie_loser_waits", obs(), ex(w_data, w_src, 1'b0, 1'b0, 1'b1));
        step();
        chk("tie_loser_grant", obs(), ex(l_data, ~w_src, w_src, ~w_src, 1'b1));
        bus.req_cpu = 1'b0;
        bus.req_dbg = 1'b0;

        // Owner refresh reloads the dwell; debug waits until N+6.
        do_reset();
        bus.req_cpu  = 1'b1;
        bus.data_cpu = 32'h0000_0001;
        step();
        chk("refresh_n", obs(), ex(32'h0000_0001, 1'b0, 1'b1, 1'b0, 1'b1));
        bus.req_cpu  = 1'b0;
        bus.req_dbg  = 1'b1;
        bus.data_dbg = B;
        step();
        chk("refresh_n1", obs(), ex(32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b1));
        bus.req_cpu  = 1'b1;
        bus.data_cpu = 32'h0000_0002;
        step();
        chk("refresh_n2", obs(), ex(32'h0000_0002, 1'b0, 1'b1, 1'b0, 1'b1));
        bus.req_cpu = 1'b0;
        for (int k = 0; k < 3; k++) step();
        chk("refresh_n5", obs(), ex(32'h0000_0002, 1'b0, 1'b0, 1'b0, 1'b1));
        step();
        chk("refresh_n6", obs(), ex(B, 1'b1, 1'b0, 1'b1, 1'b1));
        bus.req_dbg = 1'b0;

        // Repeated ties at each expiry: alternate with round-robin, CPU otherwise.
        do_reset();
        cur_cpu = 32'hC000_0000;
        cur_dbg = 32'hD000_0000;
        bus.req_cpu  = 1'b1;
        bus.data_cpu = cur_cpu;
        bus.req_dbg  = 1'b1;
        bus.data_dbg = cur_dbg;
        for (int k = 0; k < 4; k++) begin
`ifdef SEG_RR_EN
            w_src = (k % 2 == 0) ? 1'b1 : 1'b0;
`else
            w_src = 1'b0;
`endif
            w_data = w_src ? cur_dbg : cur_cpu;
            step();
            chk($sformatf("tie_seq%0d", k), obs(), ex(w_data, w_src, ~w_src, w_src, 1'b1));
            if (w_src) bus.req_dbg = 1'b0;
            else       bus.req_cpu = 1'b0;
            for (int j = 0; j < 3; j++) step();
            if (w_src) begin
                cur_dbg = cur_dbg + 32'd1;
                bus.data_dbg = cur_dbg;
                bus.req_dbg  = 1'b1;
            end else begin
                cur_cpu = cur_cpu + 32'd1;
                bus.data_cpu = cur_cpu;
                bus.req_cpu  = 1'b1;
            end
        end
        bus.req_cpu = 1'b0;
        bus.req_dbg = 1'b0;
        for (int k = 0; k < 10; k++) step();
        chk("final_idle_busy", {35'd0, bus.busy}, 36'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
